// File: rtl/bp_stream_pump_in_gen.sv
// bp_stream_pump_in_gen: inbound stream pump between an xce mem bus and a CCE/UCE FSM.
// Buffers header+data beats in a FIFO and emits one addressed stream beat per FSM yumi.
// Ports:
//   clk_i, reset_n_i                      clock, async active-low reset
//   mem_header_i/mem_data_i/mem_v_i       inbound beat (ready-valid with mem_ready_o)
//   fsm_base_header_o/fsm_addr_o/fsm_data_o/fsm_v_o/fsm_yumi_i   outbound beat (valid-yumi)
//   beat_idx_o, new_o, done_o             beat ordinal, first/last beat handshake strobes
package bp_stream_pump_pkg;
  localparam int paddr_width_gp = 40;

  localparam logic [3:0] e_mem_rd    = 4'd0;
  localparam logic [3:0] e_mem_wr    = 4'd1;
  localparam logic [3:0] e_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_mem_uc_wr = 4'd3;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [3:0]                subop;
    logic [paddr_width_gp-1:0] addr;
    logic [2:0]                size;
    logic [15:0]               payload;
  } bp_bedrock_xce_mem_msg_header_s;
endpackage

module bp_stream_pump_in_gen
  import bp_stream_pump_pkg::*;
#(
  parameter int          stream_data_width_p = 64,
  parameter int          block_width_p       = 512,
  parameter logic [15:0] payload_mask_p      = '0,
  parameter int          fifo_els_p          = 2,
  parameter bit          wrap_mode_p         = 1'b1,
  localparam int words_lp = block_width_p / stream_data_width_p,
  localparam int lw_lp    = $clog2(words_lp),
  localparam int ow_lp    = $clog2(stream_data_width_p / 8)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  bp_bedrock_xce_mem_msg_header_s mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  output logic                           mem_ready_o,
  output bp_bedrock_xce_mem_msg_header_s fsm_base_header_o,
  output logic [paddr_width_gp-1:0]      fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_yumi_i,
  output logic [lw_lp-1:0]               beat_idx_o,
  output logic                           new_o,
  output logic                           done_o
);

  localparam int pa_lp = paddr_width_gp;
  localparam int bo_lp = ow_lp + lw_lp;
  localparam int pw_lp = $clog2(fifo_els_p);
  localparam int cw_lp = $clog2(fifo_els_p + 1);

  typedef logic [lw_lp:0]   num_t;
  typedef logic [lw_lp-1:0] idx_t;
  typedef logic [pw_lp-1:0] ptr_t;
  typedef logic [cw_lp-1:0] cnt_t;
  typedef bp_bedrock_xce_mem_msg_header_s hdr_t;

  typedef enum logic {
    e_ready,
    e_stream
  } state_e;

  hdr_t                           fifo_hdr_q  [fifo_els_p];
  logic [stream_data_width_p-1:0] fifo_data_q [fifo_els_p];

  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  cnt_t   count_q, count_d;
  logic   ready_q;
  state_e state_q, state_d;
  idx_t   cnt_q, cnt_d;
  logic [bo_lp-1:0] crit_q, crit_d;
  hdr_t   hdr_q, hdr_d;

  hdr_t head_hdr, base_hdr;
  logic head_v, push, pop, hs, last, has_data;
  num_t n_beats;
  idx_t m, f, sum, word;

  // Beat count from log2 byte size, computed as a shift so a full
  // block never collapses to zero.
  function automatic num_t beats(input logic [2:0] size);
    int   sh;
    num_t n;
    sh = int'(size) - ow_lp;
    if (sh <= 0)          n = num_t'(1);
    else if (sh >= lw_lp) n = num_t'(words_lp);
    else                  n = num_t'(1) << sh;
    return n;
  endfunction

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(fifo_els_p - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign head_hdr    = fifo_hdr_q[rd_ptr_q];
  assign head_v      = (count_q != '0);
  assign mem_ready_o = ready_q & (count_q != cnt_t'(fifo_els_p));
  assign push        = mem_v_i & mem_ready_o;

  // Mid-burst the header comes from the copy taken at the first beat,
  // so later input beats' headers never leak out.
  always_comb begin
    base_hdr = head_hdr;
    if (state_q == e_stream) begin
      base_hdr = hdr_q;
      base_hdr.addr[bo_lp-1:0] = crit_q;
    end
  end

  assign has_data = payload_mask_p[base_hdr.msg_type];
  assign n_beats  = beats(base_hdr.size);
  assign m        = idx_t'(n_beats - num_t'(1));
  assign f        = base_hdr.addr[ow_lp +: lw_lp];
  assign sum      = f + cnt_q;
  assign word     = wrap_mode_p ? ((f & ~m) | (sum & m)) : sum;

  assign last   = (cnt_q == m);
  assign hs     = head_v & fsm_yumi_i;
  assign new_o  = hs & (state_q == e_ready);
  assign done_o = hs & last;
  // Non-data bursts replay the single head beat until the last one.
  assign pop    = hs & (has_data | last);

  assign fsm_v_o           = head_v;
  assign fsm_data_o        = fifo_data_q[rd_ptr_q];
  assign fsm_base_header_o = base_hdr;
  assign beat_idx_o        = cnt_q;
  assign fsm_addr_o        = {base_hdr.addr[pa_lp-1:bo_lp], word,
                              base_hdr.addr[ow_lp-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crit_d  = crit_q;
    hdr_d   = hdr_q;
    unique case (state_q)
      e_ready: begin
        if (hs) begin
          crit_d = head_hdr.addr[bo_lp-1:0];
          hdr_d  = head_hdr;
          if (!last) begin
            state_d = e_stream;
            cnt_d   = idx_t'(1);
          end
        end
      end
      e_stream: begin
        if (hs) begin
          if (last) begin
            state_d = e_ready;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + idx_t'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = pop  ? inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      state_q  <= e_ready;
      cnt_q    <= '0;
      crit_q   <= '0;
      hdr_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= 1'b1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crit_q   <= crit_d;
      hdr_q    <= hdr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_hdr_q[wr_ptr_q]  <= mem_header_i;
      fifo_data_q[wr_ptr_q] <= mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!fsm_yumi_i || fsm_v_o)
        else $error("fsm_yumi_i without fsm_v_o");
      assert (!new_o || (head_hdr.addr[ow_lp-1:0] == '0))
        else $error("critical addr not stream aligned");
    end
  end

endmodule
